// File: rtl/cpu_pkg.sv
// Shared definitions for the program/data memory subsystem: default widths
// and the loader/run FSM state encoding.
package cpu_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } state_e;

endpackage

// File: rtl/sync_ram.sv
// Single-port synchronous RAM: one write port, registered read-before-write
// output that holds its value while re is low.
module sync_ram
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Array is deliberately not reset so contents survive a reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[addr];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/prog_mem_subsys.sv
// Instruction/data memory subsystem with a streaming program loader that
// gates CPU execution until a complete program has been written.
module prog_mem_subsys
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              cpu_enable,
  output logic [ADDR_W:0]   load_count,
  output logic              load_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] load_count_q, load_count_d;
  logic             load_err_q, load_err_d;
  logic             im_we;
  logic             im_re;
  logic [ADDR_W-1:0] im_addr;
  logic             dm_we;
  logic             dm_re;

  // Next-state, load counter and IM write strobe.
  always_comb begin
    state_d      = state_q;
    load_count_d = load_count_q;
    load_err_d   = load_err_q;
    im_we        = 1'b0;
    unique case (state_q)
      IDLE, RUN, ERR: begin
        if (load_start) begin
          state_d      = LOAD;
          load_count_d = '0;
          load_err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (load_start) begin
          // Restart drops any word offered in the same cycle.
          load_count_d = '0;
        end else if (ld_valid) begin
          im_we        = 1'b1;
          load_count_d = load_count_q + CNT_W'(1);
          if (ld_last) begin
            state_d = RUN;
          end else if (load_count_q == LAST_ADDR) begin
            state_d    = ERR;
            load_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      load_count_q <= '0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_count_q <= load_count_d;
      load_err_q   <= load_err_d;
    end
  end

  // IM port belongs to the loader in LOAD and to the fetch path otherwise.
  assign im_addr = (state_q == LOAD) ? load_count_q[ADDR_W-1:0] : pc;
  assign im_re   = (state_q == RUN);
  assign dm_we   = (state_q == RUN) && d_we;
  assign dm_re   = (state_q == RUN);

  sync_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_im (
    .clock (clock),
    .reset (reset),
    .we    (im_we),
    .re    (im_re),
    .addr  (im_addr),
    .wdata (ld_data),
    .rdata (instr)
  );

  sync_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dm (
    .clock (clock),
    .reset (reset),
    .we    (dm_we),
    .re    (dm_re),
    .addr  (d_addr),
    .wdata (d_wdata),
    .rdata (d_rdata)
  );

  assign ld_ready   = (state_q == LOAD);
  assign cpu_enable = (state_q == RUN);
  assign load_count = load_count_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_prog_mem_subsys.sv
// Scoreboard bench for prog_mem_subsys: loads programs, fetches, exercises
// data memory, overflow, restart and asynchronous reset behaviour.
module tb_prog_mem_subsys;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 256;

  logic              clock = 1'b0;
  logic              reset;
  logic              load_start;
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] d_addr;
  logic              d_we;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              cpu_enable;
  logic [ADDR_W:0]   load_count;
  logic              load_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] im_model [DEPTH];
  logic [DATA_W-1:0] dm_model [DEPTH];
  logic [DATA_W-1:0] prog     [DEPTH];
  logic [DATA_W-1:0] exp_q [$];

  prog_mem_subsys #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_start (load_start),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .pc         (pc),
    .instr      (instr),
    .d_addr     (d_addr),
    .d_we       (d_we),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .cpu_enable (cpu_enable),
    .load_count (load_count),
    .load_err   (load_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [ADDR_W-1:0] a);
    pc = a;
    exp_q.push_back(im_model[a]);
    @(negedge clock);
    chk("instr", 32'(instr), 32'(exp_q.pop_front()));
  endtask

  task automatic dm_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit takes);
    d_addr  = a;
    d_wdata = d;
    d_we    = 1'b1;
    @(negedge clock);
    d_we = 1'b0;
    if (takes) dm_model[a] = d;
  endtask

  task automatic dm_read(input logic [ADDR_W-1:0] a);
    d_addr = a;
    d_we   = 1'b0;
    exp_q.push_back(dm_model[a]);
    @(negedge clock);
    chk("d_rdata", 32'(d_rdata), 32'(exp_q.pop_front()));
  endtask

  // Pulse load_start, then stream prog[0..n-1]; toggle inserts idle cycles.
  task automatic load_words(input int n, input bit toggle, input bit set_last);
    int i;
    int cyc;
    i   = 0;
    cyc = 0;
    @(negedge clock);
    load_start = 1'b1;
    @(negedge clock);
    load_start = 1'b0;
    chk("ld_ready_in_load", 32'(ld_ready), 32'd1);
    chk("cpu_en_in_load", 32'(cpu_enable), 32'd0);
    chk("count_cleared", 32'(load_count), 32'd0);
    chk("err_cleared", 32'(load_err), 32'd0);
    while (i < n) begin
      ld_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      ld_data  = ld_valid ? prog[i] : 16'hDEAD;
      ld_last  = ld_valid && set_last && (i == n - 1);
      @(negedge clock);
      if (ld_valid) begin
        im_model[i] = prog[i];
        i++;
      end
      cyc++;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    load_start = 1'b0;
    ld_valid   = 1'b0;
    ld_data    = '0;
    ld_last    = 1'b0;
    pc         = '0;
    d_addr     = '0;
    d_we       = 1'b0;
    d_wdata    = '0;
    repeat (3) @(negedge clock);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_cpu_en", 32'(cpu_enable), 32'd0);
    chk("rst_count", 32'(load_count), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_rdata", 32'(d_rdata), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_ld_ready", 32'(ld_ready), 32'd0);

    // Basic 4-word program.
    prog[0] = 16'h1111; prog[1] = 16'h2222; prog[2] = 16'h3333; prog[3] = 16'h4444;
    load_words(4, 1'b0, 1'b1);
    chk("run_cpu_en", 32'(cpu_enable), 32'd1);
    chk("run_count", 32'(load_count), 32'd4);
    chk("run_ld_ready", 32'(ld_ready), 32'd0);
    fetch(8'd2);
    fetch(8'd0);
    fetch(8'd1);
    fetch(8'd3);

    // Data memory: write-then-read, then same-cycle read/write.
    dm_write(8'h10, 16'hBEEF, 1'b1);
    dm_read(8'h10);
    dm_write(8'h20, 16'h5555, 1'b1);
    d_addr  = 8'h20;
    d_wdata = 16'h6666;
    d_we    = 1'b1;
    exp_q.push_back(dm_model[8'h20]);
    @(negedge clock);
    d_we = 1'b0;
    dm_model[8'h20] = 16'h6666;
    chk("same_cycle_old", 32'(d_rdata), 32'(exp_q.pop_front()));
    dm_read(8'h20);

    // Reload from RUN; instr holds during LOAD, DM preserved.
    prog[0] = 16'hAAAA;
    load_words(1, 1'b0, 1'b1);
    chk("instr_hold", 32'(instr), 32'h4444);
    chk("reload_cpu_en", 32'(cpu_enable), 32'd1);
    fetch(8'd0);
    dm_read(8'h10);

    // Asynchronous reset after 2 of 4 words.
    prog[0] = 16'hC001; prog[1] = 16'hC002; prog[2] = 16'hC003; prog[3] = 16'hC004;
    @(negedge clock);
    load_start = 1'b1;
    @(negedge clock);
    load_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ld_valid = 1'b1;
      ld_data  = prog[k];
      @(negedge clock);
      im_model[k] = prog[k];
    end
    chk("mid_count", 32'(load_count), 32'd2);
    ld_data = prog[2];
    reset   = 1'b1;
    #1;
    chk("arst_ld_ready", 32'(ld_ready), 32'd0);
    chk("arst_cpu_en", 32'(cpu_enable), 32'd0);
    chk("arst_count", 32'(load_count), 32'd0);
    chk("arst_err", 32'(load_err), 32'd0);
    chk("arst_instr", 32'(instr), 32'd0);
    chk("arst_rdata", 32'(d_rdata), 32'd0);
    @(negedge clock);
    reset    = 1'b0;
    ld_valid = 1'b0;

    // DM write in IDLE must be ignored.
    dm_write(8'h10, 16'h0000, 1'b0);
    chk("idle_instr", 32'(instr), 32'd0);
    chk("idle_count", 32'(load_count), 32'd0);

    // Gapped valid: only valid cycles written, no holes.
    prog[0] = 16'h0A01; prog[1] = 16'h0A02; prog[2] = 16'h0A03;
    load_words(3, 1'b1, 1'b1);
    chk("gap_count", 32'(load_count), 32'd3);
    chk("gap_cpu_en", 32'(cpu_enable), 32'd1);
    fetch(8'd0);
    fetch(8'd1);
    fetch(8'd2);
    fetch(8'd3);
    dm_read(8'h10);

    // Overflow: 256 words without ld_last.
    for (int k = 0; k < int'(DEPTH); k++) prog[k] = 16'h5000 + 16'(k);
    load_words(int'(DEPTH), 1'b0, 1'b0);
    chk("ovf_err", 32'(load_err), 32'd1);
    chk("ovf_cpu_en", 32'(cpu_enable), 32'd0);
    chk("ovf_ld_ready", 32'(ld_ready), 32'd0);
    chk("ovf_count", 32'(load_count), 32'd256);
    ld_valid = 1'b1;
    ld_data  = 16'hDEAD;
    @(negedge clock);
    ld_valid = 1'b0;
    chk("err_ignores_valid", 32'(load_count), 32'd256);
    chk("err_sticky", 32'(load_err), 32'd1);

    // Restart mid-load discards the word offered with load_start.
    @(negedge clock);
    load_start = 1'b1;
    @(negedge clock);
    load_start = 1'b0;
    chk("err_exit_clear", 32'(load_err), 32'd0);
    chk("err_exit_ready", 32'(ld_ready), 32'd1);
    prog[0] = 16'h7001; prog[1] = 16'h7002;
    for (int k = 0; k < 2; k++) begin
      ld_valid = 1'b1;
      ld_data  = prog[k];
      @(negedge clock);
      im_model[k] = prog[k];
    end
    load_start = 1'b1;
    ld_valid   = 1'b1;
    ld_data    = 16'hDEAD;
    @(negedge clock);
    load_start = 1'b0;
    chk("restart_count", 32'(load_count), 32'd0);
    chk("restart_ready", 32'(ld_ready), 32'd1);
    ld_data = 16'h7777;
    ld_last = 1'b1;
    @(negedge clock);
    im_model[0] = 16'h7777;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("restart_cpu_en", 32'(cpu_enable), 32'd1);
    chk("restart_load_cnt", 32'(load_count), 32'd1);
    fetch(8'd0);
    fetch(8'd1);
    fetch(8'd255);
    dm_read(8'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_mem_subsys.md
PROG_MEM_SUBSYS -- requirements
Module: prog_mem_subsys

Interface
REQ-001 SHALL have parameter DATA_W, default 16, instruction/data word width.
REQ-002 SHALL have parameter ADDR_W, default 8, address width; DEPTH = 2**ADDR_W words per memory.
REQ-003 SHALL have port clock  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port load_start  input  1  one-cycle request to (re)load instruction memory.
REQ-006 SHALL have port ld_valid  input  1  loader word valid.
REQ-007 SHALL have port ld_ready  output  1  loader word accepted when high with ld_valid.
REQ-008 SHALL have port ld_data  input  DATA_W  loader instruction word.
REQ-009 SHALL have port ld_last  input  1  marks final word of the program.
REQ-010 SHALL have port pc  input  ADDR_W  CPU instruction fetch address.
REQ-011 SHALL have port instr  output  DATA_W  fetched instruction, registered.
REQ-012 SHALL have ports d_addr  input  ADDR_W, d_we  input  1, d_wdata  input  DATA_W: CPU data-memory access.
REQ-013 SHALL have port d_rdata  output  DATA_W  data-memory read word, registered.
REQ-014 SHALL have port cpu_enable  output  1  CPU run permission.
REQ-015 SHALL have ports load_count  output  ADDR_W+1 (words loaded) and load_err  output  1 (overflow).

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, RUN, ERR.
REQ-017 IDLE: cpu_enable=0, ld_ready=0; load_start -> LOAD next cycle, load_count cleared to 0.
REQ-018 LOAD: ld_ready=1; each cycle with ld_valid&&ld_ready SHALL write ld_data to IM[load_count] and increment load_count.
REQ-019 LOAD: accepted word with ld_last=1 SHALL be written, then state -> RUN next cycle.
REQ-020 LOAD: accepted word at address DEPTH-1 with ld_last=0 SHALL be written, then state -> ERR, load_err=1.
REQ-021 ld_valid while ld_ready=0 SHALL be ignored (no write, no count change).
REQ-022 RUN: cpu_enable=1; IM read address = pc; instr = IM[pc] one cycle after pc presented.
REQ-023 DM SHALL be read/written only in RUN: d_we=1 writes d_wdata to DM[d_addr]; d_rdata = DM[d_addr] one cycle later; d_we outside RUN ignored.
REQ-024 Write-then-read same DM address in consecutive cycles SHALL return new data; same-cycle read/write SHALL return old data.
REQ-025 load_start in RUN or ERR SHALL go to LOAD next cycle; cpu_enable drops to 0 in that same next cycle; load_count and load_err cleared; DM contents preserved.
REQ-026 load_start in LOAD SHALL restart loading at address 0 (load_count=0); any word accepted that cycle is discarded.
REQ-027 ERR: cpu_enable=0, ld_ready=0, load_err=1 sticky until load_start or reset.
REQ-028 ld_ready and cpu_enable SHALL be decoded from the registered state only (no combinational path from inputs).
REQ-029 instr SHALL hold its last value outside RUN.

Reset
REQ-030 On reset: state=IDLE, load_count=0, load_err=0, cpu_enable=0, ld_ready=0, instr=0, d_rdata=0.
REQ-031 Reset mid-LOAD SHALL abort immediately; partial IM contents undefined-but-unchanged; memory arrays are not cleared.

Structure
REQ-032 State encoding and default DATA_W/ADDR_W SHALL live in shared package cpu_pkg.
REQ-033 One sub-module sync_ram (parametrised DATA_W/ADDR_W, one write port, registered read) SHALL be instantiated twice (IM, DM).
REQ-034 IM address/write-enable mux (loader vs pc) SHALL sit in prog_mem_subsys, selected by state.

Verification
REQ-035 Reset, load_start, stream 4 words 0x1111,0x2222,0x3333,0x4444 (last on 4th) -> RUN, load_count=4, pc=2 gives instr=0x3333 next cycle.
REQ-036 ld_valid toggling 1/0 each cycle during load of 3 words -> only valid cycles written, load_count=3, no gaps in IM.
REQ-037 Stream 256 words with ld_last never set (ADDR_W=8) -> ERR after word 255, load_err=1, cpu_enable=0, ld_ready=0.
REQ-038 RUN: d_we=1 d_addr=0x10 d_wdata=0xBEEF, then read 0x10 -> d_rdata=0xBEEF; d_we=1 in IDLE at 0x10 with 0x0000 -> DM still 0xBEEF.
REQ-039 load_start during RUN -> cpu_enable=0 next cycle, reload 1 word 0xAAAA -> RUN, instr at pc=0 = 0xAAAA, DM[0x10] still 0xBEEF.
REQ-040 Assert reset after 2 of 4 words in LOAD -> all outputs at reset values immediately (asynchronously), state IDLE.
